// File: rtl/attention_score_mh.sv
// attention_score_mh: multi-head Q.K^T score engine.
// Loads SEQ_LEN key tokens into a buffer. Then, for each of SEQ_LEN queries, it
// streams one saturated score per head for every key. The scores come out in
// key order. Define ATTN_SCORE_ROUND_EN to make the score rescale round-half-up
// instead of truncating.
module attention_score_mh #(
  parameter int DATA_WIDTH = 8,
  parameter int SEQ_LEN    = 16,
  parameter int NUM_HEADS  = 4,
  parameter int HEAD_DIM   = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_SHIFT  = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        k_valid,
  output logic                                        k_ready,
  input  logic [NUM_HEADS*HEAD_DIM*DATA_WIDTH-1:0]    k_data,
  input  logic                                        q_valid,
  output logic                                        q_ready,
  input  logic [NUM_HEADS*HEAD_DIM*DATA_WIDTH-1:0]    q_data,
  output logic                                        s_valid,
  input  logic                                        s_ready,
  output logic [NUM_HEADS*DATA_WIDTH-1:0]             s_data,
  output logic [$clog2(SEQ_LEN)-1:0]                  s_key,
  output logic                                        s_last,
  output logic                                        busy,
  output logic                                        done
);

  localparam int ROW_W = NUM_HEADS*HEAD_DIM*DATA_WIDTH;
  localparam int JW    = $clog2(SEQ_LEN);
  localparam int QW    = $clog2(SEQ_LEN+1);
  localparam int CW    = $clog2(HEAD_DIM+1);
  localparam int PW    = 2*DATA_WIDTH;
  localparam logic [JW-1:0] LAST_J = JW'(SEQ_LEN-1);
  localparam logic [CW-1:0] D_LAST = CW'(HEAD_DIM);
  localparam logic [QW-1:0] Q_ALL  = QW'(SEQ_LEN);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1)-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [2:0] {IDLE, LOAD_K, WAIT_Q, MAC, OUT, FIN} state_t;

  state_t            state_reg, state_next;
  logic [JW-1:0]     kidx_reg;   // next key row to write
  logic [JW-1:0]     j_reg;      // key currently being scored
  logic [QW-1:0]     qcnt_reg;   // queries consumed this run
  logic [CW-1:0]     d_reg;      // 0 = key row fetch, 1..HEAD_DIM = accumulate element d-1
  logic [CW-1:0]     d_idx;
  logic [ROW_W-1:0]  q_reg;
  logic [ROW_W-1:0]  k_row;
  logic [ROW_W-1:0]  kmem [SEQ_LEN];
  logic              acc_clear, acc_en;

  assign d_idx     = d_reg - 1'b1;
  assign acc_en    = (state_reg == MAC) && (d_reg != '0);
  assign acc_clear = ((state_reg == WAIT_Q) && q_valid) ||
                     ((state_reg == OUT) && s_ready && (j_reg != LAST_J));
  assign s_key     = j_reg;
  assign s_last    = (state_reg == OUT) && (j_reg == LAST_J);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_next = state_reg;
    k_ready    = 1'b0;
    q_ready    = 1'b0;
    s_valid    = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD_K;
      end
      LOAD_K: begin
        k_ready = 1'b1;
        if (k_valid && (kidx_reg == LAST_J)) state_next = WAIT_Q;
      end
      WAIT_Q: begin
        q_ready = 1'b1;
        if (q_valid) state_next = MAC;
      end
      MAC: begin
        if (d_reg == D_LAST) state_next = OUT;
      end
      OUT: begin
        s_valid = 1'b1;
        if (s_ready) begin
          if (j_reg != LAST_J)      state_next = MAC;
          else if (qcnt_reg < Q_ALL) state_next = WAIT_Q;
          else                       state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run counters and query latch
  always_ff @(posedge clk) begin
    if (rst) begin
      kidx_reg <= '0;
      j_reg    <= '0;
      qcnt_reg <= '0;
      d_reg    <= '0;
      q_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          kidx_reg <= '0;
          qcnt_reg <= '0;
        end
        LOAD_K: if (k_valid) kidx_reg <= (kidx_reg == LAST_J) ? '0 : kidx_reg + 1'b1;
        WAIT_Q: if (q_valid) begin
          q_reg    <= q_data;
          j_reg    <= '0;
          qcnt_reg <= qcnt_reg + 1'b1;
          d_reg    <= '0;
        end
        MAC: if (d_reg != D_LAST) d_reg <= d_reg + 1'b1;
        OUT: if (s_ready && (j_reg != LAST_J)) begin
          j_reg <= j_reg + 1'b1;
          d_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // Key buffer write port (block RAM, no reset)
  always_ff @(posedge clk) begin
    if (!rst && (state_reg == LOAD_K) && k_valid) kmem[kidx_reg] <= k_data;
  end

  // Key buffer registered read; the row is valid from the second MAC cycle onward
  always_ff @(posedge clk) begin
    k_row <= kmem[j_reg];
  end

  for (genvar gi = 0; gi < NUM_HEADS; gi++) begin : g_head
    logic signed [DATA_WIDTH-1:0] q_el, k_el;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc_reg, acc_adj, shifted;
    logic [DATA_WIDTH-1:0]        score;

    // Select element d-1 of this head from the latched query and the fetched key row
    always_comb begin
      q_el = '0;
      k_el = '0;
      for (int d = 0; d < HEAD_DIM; d++) begin
        if (d_idx == CW'(d)) begin
          q_el = q_reg[(gi*HEAD_DIM+d)*DATA_WIDTH +: DATA_WIDTH];
          k_el = k_row[(gi*HEAD_DIM+d)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign prod = q_el * k_el;

    // Per-head accumulator, cleared whenever a new key is about to be scored
    always_ff @(posedge clk) begin
      if (rst)            acc_reg <= '0;
      else if (acc_clear) acc_reg <= '0;
      else if (acc_en)    acc_reg <= acc_reg + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end

`ifdef ATTN_SCORE_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(2**(OUT_SHIFT-1));
    assign acc_adj = acc_reg + ROUND_BIAS;
`else
    assign acc_adj = acc_reg;
`endif
    assign shifted = acc_adj >>> OUT_SHIFT;

    // Clamp the rescaled accumulator into the signed output range
    always_comb begin
      if (shifted > SAT_MAX)      score = SAT_MAX[DATA_WIDTH-1:0];
      else if (shifted < SAT_MIN) score = SAT_MIN[DATA_WIDTH-1:0];
      else                        score = shifted[DATA_WIDTH-1:0];
    end

    assign s_data[gi*DATA_WIDTH +: DATA_WIDTH] = (state_reg == OUT) ? score : '0;
  end

endmodule

// File: tb/tb_attention_score_mh.sv
// Scoreboard testbench for attention_score_mh. The driver pushes the expected
// scores when it issues each query. A negedge monitor pops them and compares
// them on every s handshake.
module tb_attention_score_mh;
  localparam int DW = 8, SL = 16, NH = 4, HD = 4, AW = 24, OS = 2;
  localparam int KW = NH*HD*DW;

  typedef struct {
    logic [NH*DW-1:0] data;
    logic [3:0]       key;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, k_valid, q_valid;
  logic s_ready = 1'b1;
  logic [KW-1:0] k_data, q_data;
  logic k_ready, q_ready, s_valid, s_last, busy, done;
  logic [NH*DW-1:0] s_data;
  logic [3:0] s_key;

  int compared = 0, mismatched = 0;
  int beats = 0, dones = 0;
  exp_t sb_q[$];
  bit bp_mode = 0, stall_arm = 0;
  int stall_cnt = 0, cyc = 0;
  bit stall_prev = 0;
  logic [NH*DW-1:0] held_data;
  logic [3:0] held_key;
  logic held_last;

  attention_score_mh #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .NUM_HEADS(NH), .HEAD_DIM(HD),
                       .ACC_WIDTH(AW), .OUT_SHIFT(OS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key), .s_last(s_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int kval(input int pat, input int j, input int h, input int d);
    case (pat)
      0: return 1;
      1: return (h < 2) ? 127 : -128;
      2: return (j % 2 == 1 && h == 0) ? ((d < 2) ? 2 : 1) : h + 1;
      3: return ((j*5 + h*3 + d*7) % 15) - 7;
      default: return 7 - ((j*3 + h*5 + d) % 13);
    endcase
  endfunction

  function automatic int qval(input int pat, input int i, input int h, input int d);
    case (pat)
      0: return 1;
      1: return 127;
      2: return 1;
      3: return ((i*3 + h + d*5) % 11) - 5;
      default: return ((i*7 + h*2 + d) % 9) - 4;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_score(input int acc);
    int a;
    a = acc;
`ifdef ATTN_SCORE_ROUND_EN
    a = a + (1 << (OS-1));
`endif
    a = a >>> OS;
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return DW'(a);
  endfunction

  function automatic logic [KW-1:0] pack(input int pat, input int idx, input bit is_q);
    logic [KW-1:0] v;
    v = '0;
    for (int h = 0; h < NH; h++)
      for (int d = 0; d < HD; d++)
        v[(h*HD+d)*DW +: DW] = DW'(is_q ? qval(pat, idx, h, d) : kval(pat, idx, h, d));
    return v;
  endfunction

  // s_ready driver: always-ready, periodic backpressure, or a 10-cycle hold on key 3
  always @(posedge clk) begin
    #1;
    cyc++;
    if (stall_cnt > 0) begin
      stall_cnt--;
      s_ready = 1'b0;
    end else if (stall_arm && s_valid && s_key == 4'd3) begin
      stall_arm = 0;
      stall_cnt = 9;
      s_ready = 1'b0;
    end else begin
      s_ready = bp_mode ? (cyc % 3 != 2) : 1'b1;
    end
  end

  // Monitor: output stability under stall, scoreboard compare on handshake, done count
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    if (stall_prev) begin
      check("stall_valid", {63'd0, s_valid}, 64'd1);
      check("stall_data", {32'd0, s_data}, {32'd0, held_data});
      check("stall_key", {60'd0, s_key}, {60'd0, held_key});
      check("stall_last", {63'd0, s_last}, {63'd0, held_last});
    end
    stall_prev = s_valid && !s_ready;
    held_data = s_data; held_key = s_key; held_last = s_last;
    if (s_valid && s_ready) begin
      exp_t e;
      beats++;
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("score", {32'd0, s_data}, {32'd0, e.data});
        check("s_key", {60'd0, s_key}, {60'd0, e.key});
        check("s_last", {63'd0, s_last}, {63'd0, e.last});
      end
    end
    if (done) dones++;
  end

  task automatic send_k(input logic [KW-1:0] data);
    bit ok = 0;
    k_data = data; k_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (k_ready) begin ok = 1; break; end
    end
    if (!ok) check("k_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1 k_valid = 1'b0;
  endtask

  task automatic wait_q_ready();
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (q_ready) begin ok = 1; break; end
    end
    if (!ok) check("q_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input int pat, input int abort_q, input bit inject);
    int d0, b0;
    bit ok;
    exp_t e;
    d0 = dones; b0 = beats;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < SL; j++) send_k(pack(pat, j, 0));
    for (int i = 0; i < SL; i++) begin
      wait_q_ready();
      if (inject && i == 2) begin
        @(posedge clk); #1 start = 1'b1; k_valid = 1'b1; k_data = {(KW/8){8'h55}};
        repeat (3) @(posedge clk);
        #1 start = 1'b0; k_valid = 1'b0;
        @(negedge clk);
        check("waitq_hold", {61'd0, q_ready, k_ready, busy}, {61'd0, 3'b101});
      end
      for (int j = 0; j < SL; j++) begin
        for (int h = 0; h < NH; h++) begin
          int acc = 0;
          for (int d = 0; d < HD; d++) acc += qval(pat, i, h, d) * kval(pat, j, h, d);
          e.data[h*DW +: DW] = ref_score(acc);
        end
        e.key = 4'(j);
        e.last = (j == SL-1);
        sb_q.push_back(e);
      end
      q_data = pack(pat, i, 1); q_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 q_valid = 1'b0;
      if (i == abort_q) begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {22'd0, k_ready, q_ready, s_valid, s_last, busy, done, s_key, s_data}, 64'd0);
        sb_q.delete();
        repeat (10) @(posedge clk);
        check("abort_no_done", 64'(dones - d0), 64'd0);
        check("abort_beats", 64'(beats - b0), 64'(abort_q*SL));
        return;
      end
    end
    ok = 0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      if (dones != d0) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    check("done_pulses", 64'(dones - d0), 64'd1);
    check("beat_count", 64'(beats - b0), 64'd256);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    $display("run pat=%0d beats=%0d", pat, beats - b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_valid = 1'b0; q_valid = 1'b0; k_data = '0; q_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {22'd0, k_ready, q_ready, s_valid, s_last, busy, done, s_key, s_data}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run(0, -1, 0);            // all ones -> score 1
    bp_mode = 1;
    run(1, -1, 0);            // saturation to 127 / -128
    bp_mode = 0; stall_arm = 1;
    run(2, -1, 0);            // per-head ramp, acc 6 rounding case, stall on key 3
    bp_mode = 1;
    run(3, 5, 1);             // start/k_valid ignored in WAIT_Q, then abort in query 5
    run(4, -1, 0);            // full run after abort, fresh key buffer
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
